// File: rtl/req_encoder_pkg.sv
// Shared types and defaults for the sequential request encoder.
// Kept small so sibling blocks can import it without dragging in logic.
package req_encoder_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_DEF-1:0] onehot(input logic [W_DEF-1:0] idx);
        logic [N_DEF-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_encoder_prio_enc_lsb.sv
// Combinational lowest-set-bit priority encoder.
// idx is 0 when vec is empty; callers qualify it with any.
module prio_enc_lsb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-W request encoder: sticky pending vector drained lowest
// index first over a registered valid/ready interface.
//
//   state | meaning
//   IDLE  | nothing presented; out_valid = 0
//   HOLD  | out_idx presented; out_valid = 1 until accepted and queue empty
module req_encoder
    import req_encoder_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    if (W != $clog2(N)) begin : g_bad_width
        $error("req_encoder: W must equal clog2(N)");
    end

    state_t         state, state_nxt;
    logic [N-1:0]   served;
    logic [N-1:0]   acc;
    logic [N-1:0]   remain;
    logic [N-1:0]   pending_nxt;
    logic [W-1:0]   idx_nxt;
    logic           valid_nxt;
    logic           overflow_nxt;
    logic [W-1:0]   sel_idx;
    logic           sel_any;

    // In IDLE nothing is served, so remain equals pending and one encoder
    // covers both the initial load and the back-to-back reload.
    prio_enc_lsb #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec (remain),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            out_idx   <= idx_nxt;
            out_valid <= valid_nxt;
            overflow  <= overflow_nxt;
        end
    end

    always_comb begin
        served = '0;
        for (int i = 0; i < N; i++) begin
            served[i] = out_valid && out_ready && (out_idx == W'(i));
        end
        acc          = enable ? req : '0;
        remain       = pending & ~served;
        pending_nxt  = remain | acc;
        overflow_nxt = |(acc & remain);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = out_idx;
        valid_nxt = out_valid;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    idx_nxt   = sel_idx;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (sel_any) begin
                        idx_nxt = sel_idx;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: directed scenarios against hand-derived values,
// then randomized traffic against a set-based reference model.
module tb_req_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the set of outstanding request numbers and what is shown.
    bit m_set [8];
    bit m_valid;
    int m_idx;
    bit m_ovf;

    always #5 clk = ~clk;

    req_encoder #(.N(8), .W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    function automatic logic [7:0] model_pending();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) if (m_set[i]) v = v | (8'h01 << i);
        return v;
    endfunction

    task automatic model_clock(input bit r, input bit e, input logic [7:0] rq, input bit rdy);
        int  taken;
        bit  hit;
        int  first;
        if (!r) begin
            for (int i = 0; i < 8; i++) m_set[i] = 0;
            m_valid = 0;
            m_idx   = 0;
            m_ovf   = 0;
            return;
        end
        taken = (m_valid && rdy) ? m_idx : -1;
        if (taken >= 0) m_set[taken] = 0;
        hit = 0;
        if (e) for (int i = 0; i < 8; i++) if (rq[i] && m_set[i]) hit = 1;
        m_ovf = hit;
        if (!m_valid || rdy) begin
            first = -1;
            for (int i = 7; i >= 0; i--) if (m_set[i]) first = i;
            if (first >= 0) begin
                m_valid = 1;
                m_idx   = first;
            end else begin
                m_valid = 0;
            end
        end
        if (e) for (int i = 0; i < 8; i++) if (rq[i]) m_set[i] = 1;
    endtask

    // Drives one cycle from a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit e, input logic [7:0] rq, input bit rdy);
        rst_n     = r;
        enable    = e;
        req       = rq;
        out_ready = rdy;
        @(posedge clk);
        model_clock(r, e, rq, rdy);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(0, 1, 8'hFF, 1);
            vectors++;
            if (pending !== 8'h00 || out_valid !== 1'b0 || overflow !== 1'b0 || out_idx !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_hold: pending=%h valid=%b ovf=%b idx=%0d, want 00/0/0/0",
                         pending, out_valid, overflow, out_idx);
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 8'h00, 1);
            vectors++;
            if (pending !== 8'h00 || out_valid !== 1'b0 || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release: pending=%h valid=%b ovf=%b, want 00/0/0",
                         pending, out_valid, overflow);
            end
        end
    endtask

    task automatic test_single();
        step(1, 1, 8'h20, 1);
        vectors++;
        if (pending !== 8'h20 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cap: pending=%h valid=%b, want 20/0", pending, out_valid);
        end
        step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 3'd5 || pending !== 8'h20) begin
            miscompares++;
            $display("FAIL single_out: valid=%b idx=%0d pending=%h, want 1/5/20",
                     out_valid, out_idx, pending);
        end
        step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL single_done: valid=%b pending=%h, want 0/00", out_valid, pending);
        end
    endtask

    task automatic test_burst();
        logic [2:0] exp_idx [3];
        logic [7:0] exp_pend [3];
        exp_idx  = '{3'd0, 3'd2, 3'd7};
        exp_pend = '{8'h85, 8'h84, 8'h80};
        step(1, 1, 8'h85, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 8'h00, 1);
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[k] || pending !== exp_pend[k]) begin
                miscompares++;
                $display("FAIL burst_seq%0d: valid=%b idx=%0d pending=%h, want 1/%0d/%h",
                         k, out_valid, out_idx, pending, exp_idx[k], exp_pend[k]);
            end
        end
        step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL burst_end: valid=%b pending=%h, want 0/00", out_valid, pending);
        end
        step(1, 1, 8'h85, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 8'h00, 0);
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h85) begin
                miscompares++;
                $display("FAIL burst_stall%0d: valid=%b idx=%0d pending=%h, want 1/0/85",
                         k, out_valid, out_idx, pending);
            end
        end
        for (int k = 0; k < 3; k++) step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL burst_drain: valid=%b pending=%h, want 0/00", out_valid, pending);
        end
    endtask

    task automatic test_overflow();
        step(1, 1, 8'h08, 0);
        step(1, 1, 8'h00, 0);
        step(1, 1, 8'h08, 0);
        vectors++;
        if (overflow !== 1'b1 || pending !== 8'h08 || out_idx !== 3'd3 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_pulse: ovf=%b pending=%h idx=%0d valid=%b, want 1/08/3/1",
                     overflow, pending, out_idx, out_valid);
        end
        step(1, 1, 8'h00, 0);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
        end
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            miscompares++;
            $display("FAIL ovf_once: valid=%b pending=%h, want 0/00", out_valid, pending);
        end
        step(1, 1, 8'h08, 1);
        step(1, 1, 8'h00, 1);
        step(1, 1, 8'h08, 1);
        vectors++;
        if (overflow !== 1'b0 || pending !== 8'h08 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rereq_served: ovf=%b pending=%h valid=%b, want 0/08/0",
                     overflow, pending, out_valid);
        end
        step(1, 1, 8'h00, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL rereq_second: valid=%b idx=%0d, want 1/3", out_valid, out_idx);
        end
        step(1, 1, 8'h00, 1);
    endtask

    task automatic test_enable();
        step(1, 1, 8'h12, 0);
        step(1, 0, 8'hFF, 0);
        vectors++;
        if (pending !== 8'h12 || out_valid !== 1'b1 || out_idx !== 3'd1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_hold: pending=%h valid=%b idx=%0d ovf=%b, want 12/1/1/0",
                     pending, out_valid, out_idx, overflow);
        end
        step(1, 0, 8'hFF, 1);
        vectors++;
        if (pending !== 8'h10 || out_idx !== 3'd4 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_drain: pending=%h idx=%0d ovf=%b, want 10/4/0",
                     pending, out_idx, overflow);
        end
        step(1, 0, 8'hFF, 1);
        step(1, 0, 8'hFF, 1);
        vectors++;
        if (pending !== 8'h00 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_empty: pending=%h valid=%b ovf=%b, want 00/0/0",
                     pending, out_valid, overflow);
        end
    endtask

    task automatic test_mid_reset();
        step(1, 1, 8'hF0, 0);
        step(1, 1, 8'h00, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 3'd4 || pending !== 8'hF0) begin
            miscompares++;
            $display("FAIL mid_setup: valid=%b idx=%0d pending=%h, want 1/4/F0",
                     out_valid, out_idx, pending);
        end
        step(0, 1, 8'h00, 0);
        vectors++;
        if (out_valid !== 1'b0 || pending !== 8'h00 || out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b pending=%h idx=%0d, want 0/00/0",
                     out_valid, pending, out_idx);
        end
        for (int c = 0; c < 3; c++) begin
            step(1, 1, 8'h00, 1);
            vectors++;
            if (out_valid !== 1'b0 || pending !== 8'h00) begin
                miscompares++;
                $display("FAIL mid_quiet%0d: valid=%b pending=%h, want 0/00", c, out_valid, pending);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rq;
        bit         e, rdy, r;
        logic [7:0] mp;
        for (int c = 0; c < 400; c++) begin
            rq  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            e   = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            r   = ($urandom_range(0, 49) != 0);
            step(r, e, rq, rdy);
            mp = model_pending();
            vectors++;
            if (out_valid !== m_valid || out_idx !== 3'(m_idx) || pending !== mp || overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL random_c%0d: valid=%b idx=%0d pending=%h ovf=%b, want %b/%0d/%h/%b",
                         c, out_valid, out_idx, pending, overflow, m_valid, m_idx, mp, m_ovf);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_enable();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/req_encoder.md
Name: req_encoder

Overview:
- Sequential 8-to-3 request encoder. It is the encoding counterpart of the team's 3-to-8 one-hot decoder.
- Captures single-cycle request pulses on N one-hot-position lines into a sticky pending vector.
- Emits the binary index of each pending request, lowest index first, over a valid/ready handshake.
- Sits between interrupt/event sources and a consumer that expects binary-coded indices.

Parameters:
- N, 8, number of request lines
- W, 3, index width; must equal clog2(N); elaboration error otherwise

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  when 0, req is ignored; queued work still drains
- req  in  N  request pulses; any number of bits may be set per cycle
- out_idx  out  W  binary index of the presented request
- out_valid  out  1  out_idx is valid
- out_ready  in  1  consumer accepts out_idx when out_valid && out_ready
- pending  out  N  registered pending vector; includes the bit currently presented
- overflow  out  1  registered one-cycle pulse: a request hit an already-pending, unserved bit

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending=0, out_idx=0, out_valid=0, overflow=0, state=IDLE.
  - Reset mid-handshake discards all queued and presented requests. No partial state survives.
- Definitions:
  - served = onehot(out_idx) when out_valid && out_ready, else 0.
  - acc = enable ? req : 0.
- Pending update:
  - pending_next = (pending & ~served) | acc.
  - A bit that is served and re-requested in the same cycle stays set.
- Overflow:
  - overflow_next = |(acc & pending & ~served).
  - The colliding request merges into the existing bit; it is not counted twice.
- Selection: lowest-set-bit priority, implemented by prio_enc_lsb.
- State IDLE (out_valid=0):
  - If pending != 0: load out_idx = lsb(pending), set out_valid=1, go to HOLD.
  - Otherwise stay in IDLE.
  - Selection uses registered pending only. Requests arriving this cycle are not eligible until the next cycle.
- State HOLD (out_valid=1):
  - out_idx is stable until the handshake completes.
  - If out_ready and (pending & ~served) != 0: load out_idx = lsb(pending & ~served) and stay in HOLD. This gives back-to-back throughput of 1 per cycle.
  - If out_ready and no other bit is pending: out_valid=0, go to IDLE. out_idx holds its last value.
  - If !out_ready: hold out_idx and out_valid.
- Latency: req at edge t → pending bit set after t+1 → out_valid after t+2 when IDLE.
- Ordering: a lower-index request arriving while a higher index is presented does not pre-empt it. It is picked at the next selection.
- enable=0: acc=0 and overflow cannot assert. Pending and HOLD drain normally.
- All outputs are registered. There is no combinational path from req or out_ready to any output.

Decomposition:
- Package req_encoder_pkg:
  - state enum {IDLE, HOLD}
  - default N=8, W=3
  - function onehot(idx) returning N bits
- Sub-module prio_enc_lsb:
  - Combinational, parameter N.
  - Inputs: vec[N-1:0].
  - Outputs: idx[W-1:0] and any (vec != 0).
  - idx=0 when vec=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF, enable=1 → pending=0, out_valid=0, overflow=0 throughout. Releasing reset with req=0 gives no activity.
- Single request: req=8'b0010_0000 for one cycle, out_ready=1 → out_valid=1 with out_idx=5 two cycles later for exactly one cycle, then pending=0.
- Burst ordering: req=8'b1000_0101 in one cycle, out_ready=1 → out_idx 0, 2, 7 on three consecutive cycles with out_valid continuously 1. With out_ready held 0, out_idx stays 0 and pending=8'h85.
- Overflow: req bit 3 pulse, then bit 3 again while it is presented and out_ready=0 → overflow pulses 1 cycle and index 3 is emitted once. Re-requesting bit 3 on the cycle it is served → overflow=0 and index 3 is emitted twice.
- Enable gating: enable=0 with req=8'hFF → no pending change. Bits pending before the gate still drain.
- Mid-operation reset: pending=8'hF0 with HOLD at idx 4, assert rst_n=0 for one cycle → the next cycle shows out_valid=0, pending=0, and nothing further is emitted.
